// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: start/busy/done handshake, operands and results of the
// sequential multiply/divide unit. The master drives requests, the slave
// (the unit itself) returns status and results.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       MDctrl;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             div_zero;
    logic             div_ovf;
    logic             result_zero;

    modport master (
        output start, MDctrl, opA, opB,
        input  busy, done, result, result_hi, div_zero, div_ovf, result_zero
    );

    modport slave (
        input  start, MDctrl, opA, opB,
        output busy, done, result, result_hi, div_zero, div_ovf, result_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle integer multiply / divide unit.
//   MDctrl 0 MUL (signed), 1 MULU, 2 DIV (signed), 3 DIVU.
//   Multiply is radix-2 shift-add on a 2*WIDTH accumulator, divide is
//   restoring division on operand magnitudes; signs are fixed up in FINISH.
//   Results and flags are registered and held until the next FINISH.
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   When defined, trivial operands (zero multiplicand/multiplier, zero
//   divisor, or |dividend| < |divisor|) run a single CALC step and the
//   result is substituted in FINISH. When undefined, latency is fixed.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [1:0]       OP_DIV   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Magnitude of a two's complement word; most-negative keeps its pattern,
    // which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v,
                                                 input logic use_sign);
        logic [WIDTH-1:0] u;
        u = v;
        return (use_sign && (v < 0)) ? ('0 - u) : u;
    endfunction

    // Conditional two's complement negation, single width.
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    // Conditional two's complement negation, double width.
    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    // Control and output registers
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             div_zero_q, div_zero_d;
    logic             div_ovf_q, div_ovf_d;
    logic             result_zero_q, result_zero_d;

    // Datapath registers (loaded on accept, no reset needed)
    logic [1:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // {hi: partial sum / remainder, lo: multiplier / quotient}
    logic [WIDTH-1:0]   mcand_q, mcand_d;  // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   opa_q, opa_d;      // original opA for divide-by-zero remainder
    logic               neg_q_q, neg_q_d;  // negate product / quotient
    logic               neg_r_q, neg_r_d;  // negate remainder
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;
`ifdef MULDIV_EARLY_OUT_EN
    logic               early_q, early_d;
`endif

    logic signed [WIDTH-1:0] opa_s;
    logic signed [WIDTH-1:0] opb_s;
    assign opa_s = bus.opA;
    assign opb_s = bus.opB;

    // Combinational temporaries
    logic               sgn_v;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_borrow;
    logic [2*WIDTH-1:0] prod_v;
    logic [WIDTH-1:0]   res_v, res_hi_v;

    // Next-state, datapath step and output load
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        result_d      = result_q;
        result_hi_d   = result_hi_q;
        div_zero_d    = div_zero_q;
        div_ovf_d     = div_ovf_q;
        result_zero_d = result_zero_q;
        op_d          = op_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        opa_d         = opa_q;
        neg_q_d       = neg_q_q;
        neg_r_d       = neg_r_q;
        dz_d          = dz_q;
        ovf_d         = ovf_q;
`ifdef MULDIV_EARLY_OUT_EN
        early_d       = early_q;
`endif

        sgn_v      = ~bus.MDctrl[0];
        a_mag      = abs_mag(opa_s, sgn_v);
        b_mag      = abs_mag(opb_s, sgn_v);

        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_borrow = div_shift < {1'b0, mcand_q};
        div_diff   = div_shift[WIDTH-1:0] - mcand_q;

        prod_v     = cond_neg_2w(acc_q, neg_q_q);
        res_v      = '0;
        res_hi_v   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CALC;
                    cnt_d   = CNT_FULL;
                    op_d    = bus.MDctrl;
                    mcand_d = bus.MDctrl[1] ? b_mag : a_mag;
                    acc_d   = {{WIDTH{1'b0}}, (bus.MDctrl[1] ? a_mag : b_mag)};
                    opa_d   = bus.opA;
                    neg_q_d = sgn_v & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
                    neg_r_d = sgn_v & bus.opA[WIDTH-1];
                    dz_d    = bus.MDctrl[1] && (bus.opB == '0);
                    ovf_d   = (bus.MDctrl == OP_DIV) && (bus.opA == MOST_NEG) && (bus.opB == '1);
`ifdef MULDIV_EARLY_OUT_EN
                    early_d = bus.MDctrl[1] ? ((bus.opB == '0) || (a_mag < b_mag))
                                            : ((a_mag == '0) || (b_mag == '0));
                    if (early_d) begin
                        cnt_d = CNT_ONE;
                    end
`endif
                end
            end

            S_CALC: begin
                if (op_q[1]) begin
                    acc_d[2*WIDTH-1:WIDTH] = div_borrow ? div_shift[WIDTH-1:0] : div_diff;
                    acc_d[WIDTH-1:0]       = {acc_q[WIDTH-2:0], ~div_borrow};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                state_d = S_DONE;
                if (op_q[1]) begin
                    res_v    = cond_neg_w(acc_q[WIDTH-1:0], neg_q_q);
                    res_hi_v = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], neg_r_q);
                end else begin
                    res_v    = prod_v[WIDTH-1:0];
                    res_hi_v = prod_v[2*WIDTH-1:WIDTH];
                end
`ifdef MULDIV_EARLY_OUT_EN
                // A single step leaves the accumulator incomplete; trivial
                // cases have closed-form results (remainder equals dividend).
                if (early_q) begin
                    res_v    = '0;
                    res_hi_v = op_q[1] ? opa_q : '0;
                end
`endif
                if (dz_q) begin
                    res_v    = '1;
                    res_hi_v = opa_q;
                end else if (ovf_q) begin
                    res_v    = MOST_NEG;
                    res_hi_v = '0;
                end
                result_d      = res_v;
                result_hi_d   = res_hi_v;
                div_zero_d    = dz_q;
                div_ovf_d     = ovf_q;
                result_zero_d = (res_v == '0);
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and architectural outputs, with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            result_q      <= '0;
            result_hi_q   <= '0;
            div_zero_q    <= 1'b0;
            div_ovf_q     <= 1'b0;
            result_zero_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            result_q      <= result_d;
            result_hi_q   <= result_hi_d;
            div_zero_q    <= div_zero_d;
            div_ovf_q     <= div_ovf_d;
            result_zero_q <= result_zero_d;
        end
    end

    // Operand, accumulator and sign-fixup registers
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        acc_q   <= acc_d;
        mcand_q <= mcand_d;
        opa_q   <= opa_d;
        neg_q_q <= neg_q_d;
        neg_r_q <= neg_r_d;
        dz_q    <= dz_d;
        ovf_q   <= ovf_d;
`ifdef MULDIV_EARLY_OUT_EN
        early_q <= early_d;
`endif
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.result      = result_q;
    assign bus.result_hi   = result_hi_q;
    assign bus.div_zero    = div_zero_q;
    assign bus.div_ovf     = div_ovf_q;
    assign bus.result_zero = result_zero_q;

endmodule
